hyperbus_cfg_boot_seq: RTL
==========================

// Module: hyperbus_cfg_boot_seq
// PURPOSE
//  Register-interface initiator: replays a compile-time table of writes into the HyperBus config regs.
//  Sets latency, timing and per-chip address ranges after reset, so the system needs no software init.
//  Sits between the SoC reg demux and the HyperBus cfg register port; owns the port until finished.
// PARAMETERS
//  NumWrites     8        table entries; 0 is legal (trivial sequence)
//  RegAddrWidth  32       reg_req_o.addr width
//  RegDataWidth  32       data width; power of two, >=16
//  reg_req_t     logic    reg-bus request struct (addr, write, wdata, wstrb, valid)
//  reg_rsp_t     logic    reg-bus response struct (rdata, error, ready)
//  BootAddr      '0       [NumWrites-1:0][RegAddrWidth-1:0] byte address per entry
//  BootData      '0       [NumWrites-1:0][RegDataWidth-1:0] write data per entry
//  BootStrb      '1       [NumWrites-1:0][RegDataWidth/8-1:0] byte strobes per entry
//  TimeoutCycles 1024     max cycles valid may wait for ready; 0 disables the timeout
// PORTS
//  clk_i      in   1                    clock
//  rst_ni     in   1                    async reset, active low
//  start_i    in   1                    pulse: run table from entry 0
//  busy_o     out  1                    sequence in progress
//  done_o     out  1                    sticky: all entries accepted without error
//  error_o    out  1                    sticky: bus error, timeout or verify mismatch
//  err_idx_o  out  $clog2(NumWrites+1)  failing entry index; NumWrites if none
//  reg_req_o  out  reg_req_t            request to cfg register block
//  reg_rsp_i  in   reg_rsp_t            response from cfg register block
// BEHAVIOUR
//  Reset: FSM IDLE, idx=0, all reg_req_o fields 0, busy/done/error=0, err_idx_o=NumWrites.
//  FSM: IDLE -start_i-> WRITE (idx=0; done/error cleared); NumWrites==0: IDLE -start_i-> DONE.
//  WRITE: valid=1, write=1, addr/wdata/wstrb=table[idx]; request held stable until ready.
//  Handshake completes in the cycle with valid & ready; rsp.error and rdata are sampled that cycle.
//  Completion with rsp.error=1 -> ERROR, err_idx_o=idx.
//  Clean completion: idx==NumWrites-1 -> DONE, else idx+1 and stay in WRITE.
//  Back-to-back: valid stays high across entries; one entry per cycle at most.
//  Wait counter: resets at each handshake; counts while valid & ~ready.
//  Counter reaching TimeoutCycles -> ERROR, err_idx_o=idx. ready is low while the PHY transfers.
//  DONE/ERROR: valid=0, busy=0, flags held; start_i re-runs the table from entry 0.
//  start_i while busy is ignored. start_i in the cycle after DONE is accepted.
//  busy_o = state in {WRITE, VERIFY}.
//  Async reset mid-sequence: valid drops to 0 immediately; no partial retry after reset.
//  The responder retains already-written values.
//  Counter width $clog2(TimeoutCycles+1); idx width $clog2(NumWrites+1); no wrap possible.
// CONFIGURATION
//  HYPERBUS_CFG_SEQ_VERIFY_EN defined: after each clean write, VERIFY state issues a read of the same addr.
//   Read: write=0, wstrb=0, same timeout and error rules as WRITE.
//   Check: (rdata ^ wdata) & strobe mask != 0 -> ERROR, err_idx_o=idx. Otherwise advance as above.
//   Each entry therefore costs >=2 handshakes.
//  Undefined: VERIFY state and compare logic absent; write-only sequence.
// STRUCTURE
//  hyperbus_pkg: cfg_seq_state_e enum {IDLE, WRITE, VERIFY, DONE, ERROR}.
//  hyperbus_pkg: function building a byte strobe mask from wstrb (shared with cfg regs).
//  No sub-module; single FSM + index counter + wait counter, FFARN-style registers.
// TESTING
//  T1: NumWrites=3, ready=1 always, start pulse -> three writes on consecutive cycles.
//      Then done_o=1 on the 4th cycle; err_idx_o=3.
//  T2: ready held low 5 cycles on entry 1 -> request stable all 5 cycles.
//      Exactly one handshake per entry; done_o=1.
//  T3: rsp.error=1 on entry 2 -> error_o=1, err_idx_o=2, valid=0 next cycle; done_o stays 0.
//  T4: TimeoutCycles=16, ready never rises -> error_o=1 after 16 waiting cycles, err_idx_o=0.
//  T5: rst_ni low during entry 1 -> all outputs at reset values in the same cycle.
//      Fresh start_i replays from entry 0.
//  T6 (VERIFY_EN): rdata differs in a strobed byte -> error_o=1 at that entry.
//      Difference only in an unstrobed byte -> done_o=1.

Source files
------------

// File: rtl/hyperbus_pkg.sv
// Shared types for the HyperBus config-register boot sequencer: FSM states,
// default reg-bus request/response structs and the byte-strobe mask helper.
package hyperbus_pkg;

    localparam int unsigned MaxDataWidth = 256;
    localparam int unsigned MaxStrbWidth = MaxDataWidth / 8;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        VERIFY,
        DONE,
        ERROR
    } cfg_seq_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } cfg_reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } cfg_reg_rsp_t;

    // Expands one strobe bit per byte into a full bit mask; upper unused
    // strobes must be zero so narrower buses can share this helper.
    function automatic logic [MaxDataWidth-1:0] strb_to_mask(input logic [MaxStrbWidth-1:0] strb);
        logic [MaxDataWidth-1:0] mask;
        mask = '0;
        for (int i = 0; i < MaxStrbWidth; i++) begin
            mask[i*8 +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/hyperbus_cfg_boot_seq.sv
// Boot-time replay of a fixed write table into the HyperBus config registers.
// Optional read-back check of every entry when HYPERBUS_CFG_SEQ_VERIFY_EN is defined.
module hyperbus_cfg_boot_seq
    import hyperbus_pkg::*;
#(
    parameter int unsigned NumWrites     = 8,
    parameter int unsigned RegAddrWidth  = 32,
    parameter int unsigned RegDataWidth  = 32,
    parameter type         reg_req_t     = hyperbus_pkg::cfg_reg_req_t,
    parameter type         reg_rsp_t     = hyperbus_pkg::cfg_reg_rsp_t,
    parameter logic [((NumWrites > 0) ? NumWrites : 1)-1:0][RegAddrWidth-1:0]   BootAddr = '0,
    parameter logic [((NumWrites > 0) ? NumWrites : 1)-1:0][RegDataWidth-1:0]   BootData = '0,
    parameter logic [((NumWrites > 0) ? NumWrites : 1)-1:0][RegDataWidth/8-1:0] BootStrb = '1,
    parameter int unsigned TimeoutCycles = 1024,
    localparam int unsigned IdxW  = (NumWrites > 0) ? $clog2(NumWrites + 1) : 1,
    localparam int unsigned WaitW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            error_o,
    output logic [IdxW-1:0] err_idx_o,
    output reg_req_t        reg_req_o,
    input  reg_rsp_t        reg_rsp_i
);

    localparam logic [IdxW-1:0]  IdxNone  = IdxW'(NumWrites);
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'((NumWrites > 0) ? NumWrites - 1 : 0);
    localparam logic [WaitW-1:0] WaitLast = WaitW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

    cfg_seq_state_e    state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [IdxW-1:0]   err_idx_q, err_idx_d;

    logic [RegAddrWidth-1:0]   cur_addr;
    logic [RegDataWidth-1:0]   cur_data;
    logic [RegDataWidth/8-1:0] cur_strb;
    logic                      req_valid;
    logic                      hs;
    logic                      timeout;
    logic                      mismatch;

    // Table lookup as an explicit mux so the index width need not match the table depth.
    always_comb begin
        cur_addr = '0;
        cur_data = '0;
        cur_strb = '0;
        for (int unsigned i = 0; i < NumWrites; i++) begin
            if (idx_q == IdxW'(i)) begin
                cur_addr = BootAddr[i];
                cur_data = BootData[i];
                cur_strb = BootStrb[i];
            end
        end
    end

    assign req_valid = (state_q == WRITE) || (state_q == VERIFY);
    assign hs        = req_valid && reg_rsp_i.ready;
    assign timeout   = (TimeoutCycles != 0) && req_valid && !reg_rsp_i.ready && (wait_q == WaitLast);

`ifdef HYPERBUS_CFG_SEQ_VERIFY_EN
    assign mismatch = |(MaxDataWidth'(reg_rsp_i.rdata ^ cur_data)
                        & strb_to_mask(MaxStrbWidth'(cur_strb)));
`else
    assign mismatch = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wait_d    = wait_q;
        done_d    = done_q;
        error_d   = error_q;
        err_idx_d = err_idx_q;

        if (req_valid && (TimeoutCycles != 0)) begin
            wait_d = hs ? '0 : wait_q + WaitW'(1);
        end

        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (start_i) begin
                    idx_d     = '0;
                    wait_d    = '0;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    err_idx_d = IdxNone;
                    if (NumWrites == 0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE, VERIFY: begin
                if (hs) begin
                    if (reg_rsp_i.error || (state_q == VERIFY && mismatch)) begin
                        state_d   = ERROR;
                        error_d   = 1'b1;
                        err_idx_d = idx_q;
`ifdef HYPERBUS_CFG_SEQ_VERIFY_EN
                    end else if (state_q == WRITE) begin
                        state_d = VERIFY;
`endif
                    end else if (idx_q == IdxLast) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WRITE;
                        idx_d   = idx_q + IdxW'(1);
                    end
                end else if (timeout) begin
                    state_d   = ERROR;
                    error_d   = 1'b1;
                    err_idx_d = idx_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            wait_q    <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= IdxNone;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wait_q    <= wait_d;
            done_q    <= done_d;
            error_q   <= error_d;
            err_idx_q <= err_idx_d;
        end
    end

    // Request is decoded from registered state only, so reset clears it immediately.
    always_comb begin
        reg_req_o = '0;
        if (req_valid) begin
            reg_req_o.valid = 1'b1;
            reg_req_o.addr  = cur_addr;
            if (state_q == WRITE) begin
                reg_req_o.write = 1'b1;
                reg_req_o.wdata = cur_data;
                reg_req_o.wstrb = cur_strb;
            end
        end
    end

    assign busy_o    = req_valid;
    assign done_o    = done_q;
    assign error_o   = error_q;
    assign err_idx_o = err_idx_q;

endmodule
